// File: rtl/filt_nch.sv
// Multi-channel glitch filter: per-channel synchroniser, then a 4-state FSM with
// separate rise/fall hold thresholds, qualified sampling and one-cycle edge pulses.
//
// state   | meaning
// --------+------------------------------------------
// ST_LOW  | y=0 stable, counter cleared
// ST_RISE | y=0, input seen high, counting high samples
// ST_HIGH | y=1 stable, counter cleared
// ST_FALL | y=1, input seen low, counting low samples
module filt_nch #(
  parameter int            CH          = 4,
  parameter int            RISE_CNT    = 10,
  parameter int            FALL_CNT    = 10,
  parameter int            SYNC_STAGES = 2,
  parameter logic [CH-1:0] INIT        = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [CH-1:0] i,
  output logic [CH-1:0] y,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  localparam int MAX_CNT = (RISE_CNT > FALL_CNT) ? RISE_CNT : FALL_CNT;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] RISE_LAST = CW'(RISE_CNT - 1);
  localparam logic [CW-1:0] FALL_LAST = CW'(FALL_CNT - 1);

  typedef enum logic [1:0] {
    ST_LOW  = 2'b00,
    ST_RISE = 2'b01,
    ST_HIGH = 2'b10,
    ST_FALL = 2'b11
  } state_t;

  logic [CH-1:0] s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][CH-1:0] sync_q;

      // Shifts every edge; tick only gates the filter itself.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= {SYNC_STAGES{INIT}};
        end else begin
          sync_q[0] <= i;
          for (int n = 1; n < SYNC_STAGES; n++) begin
            sync_q[n] <= sync_q[n-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  for (genvar c = 0; c < CH; c++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          y_q, y_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= INIT[c] ? ST_HIGH : ST_LOW;
        cnt_q   <= '0;
        y_q     <= INIT[c];
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        y_q     <= y_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        ST_LOW: begin
          if (tick) begin
            if (!s[c]) begin
              cnt_d = '0;
            end else if (RISE_CNT == 1) begin
              state_d = ST_HIGH;
              y_d     = 1'b1;
              rise_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = ST_RISE;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_RISE: begin
          if (tick) begin
            if (!s[c]) begin
              state_d = ST_LOW;
              cnt_d   = '0;
            end else if (cnt_q == RISE_LAST) begin
              state_d = ST_HIGH;
              y_d     = 1'b1;
              rise_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_HIGH: begin
          if (tick) begin
            if (s[c]) begin
              cnt_d = '0;
            end else if (FALL_CNT == 1) begin
              state_d = ST_LOW;
              y_d     = 1'b0;
              fall_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = ST_FALL;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_FALL: begin
          if (tick) begin
            if (s[c]) begin
              state_d = ST_HIGH;
              cnt_d   = '0;
            end else if (cnt_q == FALL_LAST) begin
              state_d = ST_LOW;
              y_d     = 1'b0;
              fall_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        // Unreachable with a 2-bit encoding, kept so a corrupted state lands in LOW.
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
          y_d     = 1'b0;
        end
      endcase
    end

    assign y[c]    = y_q;
    assign rise[c] = rise_q;
    assign fall[c] = fall_q;
  end

endmodule

// File: tb/tb_filt_nch.sv
// Directed bench for filt_nch: four instances cover defaults, INIT, asymmetric
// thresholds and tick prescaling; expected values are hand-computed edge counts.
module tb_filt_nch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_def = 1'b1;
  logic       tick_tck = 1'b1;
  logic [3:0] i_def = '0, i_ini = 4'b1010, i_asy = '0, i_tck = '0;
  logic [3:0] y_def, rise_def, fall_def;
  logic [3:0] y_ini, rise_ini, fall_ini;
  logic [3:0] y_asy, rise_asy, fall_asy;
  logic [3:0] y_tck, rise_tck, fall_tck;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  filt_nch dut_def (
    .clk(clk), .rst_n(rst_n), .tick(tick_def), .i(i_def),
    .y(y_def), .rise(rise_def), .fall(fall_def)
  );

  filt_nch #(.INIT(4'b1010)) dut_ini (
    .clk(clk), .rst_n(rst_n), .tick(tick_def), .i(i_ini),
    .y(y_ini), .rise(rise_ini), .fall(fall_ini)
  );

  filt_nch #(.RISE_CNT(3), .FALL_CNT(20), .SYNC_STAGES(0)) dut_asy (
    .clk(clk), .rst_n(rst_n), .tick(tick_def), .i(i_asy),
    .y(y_asy), .rise(rise_asy), .fall(fall_asy)
  );

  filt_nch #(.RISE_CNT(5)) dut_tck (
    .clk(clk), .rst_n(rst_n), .tick(tick_tck), .i(i_tck),
    .y(y_tck), .rise(rise_tck), .fall(fall_tck)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vectors++;
    if (y_def !== 4'b0000 || y_ini !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_level: y_def=%b y_ini=%b required 0000/1010", y_def, y_ini);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      step();
      vectors++;
      if (y_def !== 4'b0000 || rise_def !== 4'b0000 || fall_def !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_hold_def cyc %0d: y=%b rise=%b fall=%b required 0000/0000/0000",
                 n, y_def, rise_def, fall_def);
      end
      vectors++;
      if (y_ini !== 4'b1010 || rise_ini !== 4'b0000 || fall_ini !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_hold_init cyc %0d: y=%b rise=%b fall=%b required 1010/0000/0000",
                 n, y_ini, rise_ini, fall_ini);
      end
    end
  endtask

  task automatic test_clean_rise();
    logic [3:0] ey, er;
    i_def = 4'b0001;
    for (int n = 1; n <= 13; n++) begin
      step();
      ey = (n >= 12) ? 4'b0001 : 4'b0000;
      er = (n == 12) ? 4'b0001 : 4'b0000;
      vectors++;
      if (y_def !== ey || rise_def !== er || fall_def !== 4'b0000) begin
        miscompares++;
        $display("FAIL clean_rise cyc %0d: y=%b rise=%b fall=%b required %b/%b/0000",
                 n, y_def, rise_def, fall_def, ey, er);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] ey, er;
    i_def = 4'b0011;
    repeat (9) step();
    i_def = 4'b0001;
    for (int n = 1; n <= 15; n++) begin
      step();
      vectors++;
      if (y_def !== 4'b0001 || rise_def !== 4'b0000 || fall_def !== 4'b0000) begin
        miscompares++;
        $display("FAIL glitch_reject cyc %0d: y=%b rise=%b fall=%b required 0001/0000/0000",
                 n, y_def, rise_def, fall_def);
      end
    end
    i_def = 4'b0011;
    for (int n = 1; n <= 13; n++) begin
      step();
      ey = (n >= 12) ? 4'b0011 : 4'b0001;
      er = (n == 12) ? 4'b0010 : 4'b0000;
      vectors++;
      if (y_def !== ey || rise_def !== er) begin
        miscompares++;
        $display("FAIL glitch_then_rise cyc %0d: y=%b rise=%b required %b/%b",
                 n, y_def, rise_def, ey, er);
      end
    end
  endtask

  task automatic test_fall_together();
    logic [3:0] ey, ef;
    i_def = 4'b0000;
    for (int n = 1; n <= 13; n++) begin
      step();
      ey = (n >= 12) ? 4'b0000 : 4'b0011;
      ef = (n == 12) ? 4'b0011 : 4'b0000;
      vectors++;
      if (y_def !== ey || fall_def !== ef || rise_def !== 4'b0000) begin
        miscompares++;
        $display("FAIL fall_together cyc %0d: y=%b fall=%b rise=%b required %b/%b/0000",
                 n, y_def, fall_def, rise_def, ey, ef);
      end
    end
  endtask

  task automatic test_asymmetric();
    logic [3:0] ey, ep;
    i_asy = 4'b0001;
    for (int n = 1; n <= 4; n++) begin
      step();
      ey = (n >= 3) ? 4'b0001 : 4'b0000;
      ep = (n == 3) ? 4'b0001 : 4'b0000;
      vectors++;
      if (y_asy !== ey || rise_asy !== ep) begin
        miscompares++;
        $display("FAIL asym_rise cyc %0d: y=%b rise=%b required %b/%b", n, y_asy, rise_asy, ey, ep);
      end
    end
    i_asy = 4'b0000;
    for (int n = 1; n <= 15; n++) begin
      step();
      vectors++;
      if (y_asy !== 4'b0001 || fall_asy !== 4'b0000) begin
        miscompares++;
        $display("FAIL asym_dip cyc %0d: y=%b fall=%b required 0001/0000", n, y_asy, fall_asy);
      end
    end
    i_asy = 4'b0001;
    repeat (5) step();
    i_asy = 4'b0000;
    for (int n = 1; n <= 21; n++) begin
      step();
      ey = (n >= 20) ? 4'b0000 : 4'b0001;
      ep = (n == 20) ? 4'b0001 : 4'b0000;
      vectors++;
      if (y_asy !== ey || fall_asy !== ep || rise_asy !== 4'b0000) begin
        miscompares++;
        $display("FAIL asym_fall cyc %0d: y=%b fall=%b rise=%b required %b/%b/0000",
                 n, y_asy, fall_asy, rise_asy, ey, ep);
      end
    end
  endtask

  task automatic test_tick();
    logic [3:0] ey, er;
    // Channel 1 drops for one cycle so its low sample lands on a non-tick edge.
    for (int j = 1; j <= 22; j++) begin
      tick_tck = (j % 4 == 0);
      i_tck    = (j == 8) ? 4'b0001 : 4'b0011;
      step();
      ey = (j >= 20) ? 4'b0011 : 4'b0000;
      er = (j == 20) ? 4'b0011 : 4'b0000;
      vectors++;
      if (y_tck !== ey || rise_tck !== er || fall_tck !== 4'b0000) begin
        miscompares++;
        $display("FAIL tick_prescale edge %0d: y=%b rise=%b fall=%b required %b/%b/0000",
                 j, y_tck, rise_tck, fall_tck, ey, er);
      end
    end
    tick_tck = 1'b1;
  endtask

  task automatic test_reset_midcount();
    logic [3:0] ey, er;
    i_def = 4'b1111;
    repeat (8) step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (y_def !== 4'b0000 || rise_def !== 4'b0000 || fall_def !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_midcount_async: y=%b rise=%b fall=%b required 0000/0000/0000",
               y_def, rise_def, fall_def);
    end
    vectors++;
    if (y_ini !== 4'b1010 || y_tck !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_midcount_others: y_ini=%b y_tck=%b required 1010/0000", y_ini, y_tck);
    end
    repeat (2) step();
    rst_n = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      step();
      ey = (n >= 12) ? 4'b1111 : 4'b0000;
      er = (n == 12) ? 4'b1111 : 4'b0000;
      vectors++;
      if (y_def !== ey || rise_def !== er || fall_def !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_then_rise cyc %0d: y=%b rise=%b fall=%b required %b/%b/0000",
                 n, y_def, rise_def, fall_def, ey, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_fall_together();
    test_asymmetric();
    test_tick();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
